// File: rtl/scope_pkg.sv
// ---------------------------------------------------------------------------
// scope_pkg
// Shared types for the scope capture sequencer: FSM state encoding, trigger
// mode encodings and small elaboration-time helpers.
// Optional feature macro used by the top: SCOPE_CAPTURE_AUTO_EN.
// ---------------------------------------------------------------------------
package scope_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_FILL        = 3'd1,
        ST_ARMED       = 3'd2,
        ST_POST        = 3'd3,
        ST_COMMIT_WAIT = 3'd4,
        ST_HOLDOFF     = 3'd5
    } state_e;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_AUTO   = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;

    // States in which incoming samples are written to the capture RAM.
    function automatic logic state_writes(input state_e s);
        return (s == ST_FILL) || (s == ST_ARMED) || (s == ST_POST);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sample_edge_det.sv
// ---------------------------------------------------------------------------
// sample_edge_det
// Rising-edge detector on the trigger level, qualified by the sample strobe.
// The previous-level register only advances on sample_tick_i, so the edge is
// defined in sample time rather than clock time.
//
// Ports:
//   clk           in  system clock
//   reset_n       in  asynchronous active-low reset
//   sample_tick_i in  sample strobe
//   trig_i        in  trigger level
//   clear_i       in  synchronous clear of the previous level (FILL entry)
//   rise_o        out rising edge seen on this sample
// ---------------------------------------------------------------------------
module sample_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_tick_i,
    input  logic trig_i,
    input  logic clear_i,
    output logic rise_o
);

    logic trig_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_prev_q <= 1'b0;
        end else if (clear_i) begin
            trig_prev_q <= 1'b0;
        end else if (sample_tick_i) begin
            trig_prev_q <= trig_i;
        end
    end

    assign rise_o = sample_tick_i & trig_i & ~trig_prev_q;

endmodule

// File: rtl/scope_capture_ctrl.sv
// ---------------------------------------------------------------------------
// scope_capture_ctrl
// Trigger and capture sequencer for the circular waveform RAM. Fills a
// pre-trigger window, hunts for a trigger edge (or an auto timeout), fills
// the remainder of the record, then hands the record over on a frame
// boundary and optionally re-arms after a holdoff.
//
// Optional feature: define SCOPE_CAPTURE_AUTO_EN to build the auto-trigger
// timeout. Without it mode 1 behaves as normal and auto_fired is 0.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   sample_tick         new-sample strobe
//   trig_in             trigger level
//   mode[1:0]           0 normal, 1 auto, 2 single, 3 normal
//   arm                 start pulse for single mode (IDLE only)
//   can_commit          frame-boundary pulse
//   capture_we          RAM write enable (combinational from sample_tick)
//   capture_addr[AW-1:0] RAM write address
//   commit              one-cycle record-valid pulse
//   start_addr[AW-1:0]  oldest sample of the committed record
//   busy                capture in progress
//   auto_fired          last trigger came from the timeout
//
// State table:
//   IDLE        | waiting to start (immediately, or on arm in single mode)
//   FILL        | writing the pre-trigger window, triggers ignored
//   ARMED       | writing and watching for a trigger edge / timeout
//   POST        | writing the post-trigger part of the record
//   COMMIT_WAIT | record complete, waiting for a frame boundary
//   HOLDOFF     | counting sample ticks before re-arming
// ---------------------------------------------------------------------------
module scope_capture_ctrl
    import scope_pkg::*;
#(
    parameter int AW           = 10,
    parameter int PRETRIG      = 128,
    parameter int HOLDOFF      = 64,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sample_tick,
    input  logic          trig_in,
    input  logic [1:0]    mode,
    input  logic          arm,
    input  logic          can_commit,
    output logic          capture_we,
    output logic [AW-1:0] capture_addr,
    output logic          commit,
    output logic [AW-1:0] start_addr,
    output logic          busy,
    output logic          auto_fired
);

    localparam int DEPTH   = 1 << AW;
    localparam int POST_N  = DEPTH - PRETRIG - 1;
    localparam int CNT_MAX = max3(PRETRIG, POST_N, HOLDOFF);
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Down-counter loads are N-1 so the terminal count is always zero.
    localparam logic [CW-1:0] FILL_LOAD = CW'(PRETRIG - 1);
    localparam logic [CW-1:0] POST_LOAD = CW'(POST_N - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);

`ifdef SCOPE_CAPTURE_AUTO_EN
    localparam int            TW      = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(AUTO_TIMEOUT - 1);
`endif

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic [AW-1:0] start_q;
    logic          commit_q;
    logic [1:0]    mode_q;

    logic          writing;
    logic          start_ok;
    logic          fill_entry;
    logic          rise;
    logic          auto_hit;
    logic          trig_hit;

`ifdef SCOPE_CAPTURE_AUTO_EN
    logic [TW-1:0] to_cnt_q;
    logic          auto_q;
`endif

    assign writing    = state_writes(state_q);
    assign capture_we = sample_tick & writing;
    assign addr_d     = capture_we ? addr_q + AW'(1) : addr_q;

    assign start_ok   = (mode != MODE_SINGLE) || arm;

    // trig_prev must be cleared on the same edge that enters FILL so a level
    // already high at the start of a capture cannot trigger.
    assign fill_entry = ((state_q == ST_IDLE) && start_ok) ||
                        ((state_q == ST_HOLDOFF) && sample_tick && (cnt_q == '0));

    sample_edge_det u_edge (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_tick_i(sample_tick),
        .trig_i       (trig_in),
        .clear_i      (fill_entry),
        .rise_o       (rise)
    );

`ifdef SCOPE_CAPTURE_AUTO_EN
    assign auto_hit = (mode_q == MODE_AUTO) && capture_we && (to_cnt_q == '0);
`else
    assign auto_hit = 1'b0;
`endif

    assign trig_hit = (state_q == ST_ARMED) && (rise || auto_hit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            start_q  <= '0;
            commit_q <= 1'b0;
            mode_q   <= MODE_NORMAL;
`ifdef SCOPE_CAPTURE_AUTO_EN
            to_cnt_q <= '0;
            auto_q   <= 1'b0;
`endif
        end else begin
            addr_q   <= addr_d;
            commit_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_q <= ST_FILL;
                        cnt_q   <= FILL_LOAD;
                        mode_q  <= mode;
                    end
                end
                ST_FILL: begin
                    if (capture_we) begin
                        if (cnt_q == '0) begin
                            state_q  <= ST_ARMED;
`ifdef SCOPE_CAPTURE_AUTO_EN
                            to_cnt_q <= TO_LOAD;
`endif
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                ST_ARMED: begin
                    if (trig_hit) begin
                        // The sample written this cycle is the trigger sample.
                        start_q <= addr_q - PRE_OFS;
                        state_q <= ST_POST;
                        cnt_q   <= POST_LOAD;
`ifdef SCOPE_CAPTURE_AUTO_EN
                        // A real edge on the timeout sample wins.
                        auto_q  <= ~rise;
`endif
                    end
`ifdef SCOPE_CAPTURE_AUTO_EN
                    else if (capture_we && (to_cnt_q != '0)) begin
                        to_cnt_q <= to_cnt_q - TW'(1);
                    end
`endif
                end
                ST_POST: begin
                    if (capture_we) begin
                        if (cnt_q == '0) begin
                            state_q <= ST_COMMIT_WAIT;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                ST_COMMIT_WAIT: begin
                    if (can_commit) begin
                        commit_q <= 1'b1;
                        cnt_q    <= HOLD_LOAD;
                        state_q  <= (mode_q == MODE_SINGLE) ? ST_IDLE : ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (sample_tick) begin
                        if (cnt_q == '0) begin
                            state_q <= ST_FILL;
                            cnt_q   <= FILL_LOAD;
                            mode_q  <= mode;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign capture_addr = addr_q;
    assign start_addr   = start_q;
    assign commit       = commit_q;
    assign busy         = (state_q == ST_FILL) || (state_q == ST_ARMED) ||
                          (state_q == ST_POST) || (state_q == ST_COMMIT_WAIT);
`ifdef SCOPE_CAPTURE_AUTO_EN
    assign auto_fired   = auto_q;
`else
    assign auto_fired   = 1'b0;
`endif

endmodule

// File: doc/scope_capture_ctrl.md
# scope_capture_ctrl

Trigger and capture sequencer for the oscilloscope waveform buffer. It receives ADC sample strobes and a trigger level, and generates write enables and addresses for a circular capture RAM. It holds a programmable pre-trigger window and hands a completed record to the display side only at a frame boundary (`can_commit`, driven from end-of-frame). The block sits between the analog front-end sampling logic and the dual-port waveform RAM that the video path reads.

## Interface
Parameters:
- `AW`, 10: capture RAM address width; record depth = 2^AW samples.
- `PRETRIG`, 128: samples kept before the trigger; must be between 1 and 2^AW-2.
- `HOLDOFF`, 64: sample ticks to wait after a commit before re-arming.
- `AUTO_TIMEOUT`, 4096: ARMED-state sample ticks before a forced trigger in auto mode.

Ports:
- `clk` in 1: single system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `sample_tick` in 1: one-cycle strobe marking a new sample on the RAM data bus.
- `trig_in` in 1: trigger level, synchronous to `clk`.
- `mode` in 2: 0 = normal, 1 = auto, 2 = single, 3 = reserved (treated as normal).
- `arm` in 1: pulse that starts a capture in single mode.
- `can_commit` in 1: frame-boundary pulse from the video timing.
- `capture_we` out 1: RAM write enable.
- `capture_addr` out AW: RAM write address.
- `commit` out 1: one-cycle pulse indicating a new record is valid.
- `start_addr` out AW: address of the oldest sample in the committed record.
- `busy` out 1: high in FILL, ARMED, POST and COMMIT_WAIT.
- `auto_fired` out 1: the last commit came from the auto timeout.

## Operation
States: IDLE, FILL, ARMED, POST, COMMIT_WAIT, HOLDOFF.

- **IDLE**
  - Mode 0, 1 or 3: go to FILL on the next cycle.
  - Mode 2: go to FILL only on `arm`.
  - `mode` is latched on leaving IDLE or HOLDOFF. Changes during a capture are ignored.
- **FILL**: write PRETRIG samples, then go to ARMED. Triggers are ignored here.
- **ARMED**
  - Write every sample and evaluate the trigger on each `sample_tick`.
  - Edge condition: `trig_in`=1 and `trig_prev`=0. `trig_prev` updates only on `sample_tick`.
  - On an edge, the sample written that same cycle is the trigger sample:
    - `trig_addr` = `capture_addr`.
    - `start_addr` is registered as (`trig_addr` − PRETRIG) mod 2^AW.
    - Go to POST.
  - Auto mode: after AUTO_TIMEOUT ARMED writes with no edge, the AUTO_TIMEOUT-th write is treated as the trigger, with the same handling as an edge, and `auto_fired` is set.
- **POST**: write 2^AW − PRETRIG − 1 further samples, then go to COMMIT_WAIT.
- **COMMIT_WAIT**
  - No writes.
  - On `can_commit`: pulse `commit` for one cycle.
  - Latched mode 2: go to IDLE. Otherwise: go to HOLDOFF.
- **HOLDOFF**: no writes. Count HOLDOFF `sample_tick`s, then go to FILL.

Datapath rules:
- `capture_we` = `sample_tick` AND state in {FILL, ARMED, POST}.
- `capture_addr` increments after every write, wrapping modulo 2^AW. It is not reset between records.
- `auto_fired` is cleared on every edge-triggered trigger and set on every timeout trigger.
- `arm` outside IDLE is ignored.
- `trig_prev` is cleared on entry to FILL, so a level that is already high does not trigger until it falls and rises again.

## Timing
- Reset values: state IDLE, `capture_we` 0, `capture_addr` 0, `commit` 0, `start_addr` 0, `busy` 0, `auto_fired` 0, all counters 0, `trig_prev` 0.
- Reset asserted mid-operation aborts the capture immediately. No `commit` is issued.
- `capture_we` follows `sample_tick` combinationally: zero latency.
- `capture_addr` is registered and updates the cycle after a write.
- `start_addr` becomes valid the cycle after the trigger sample. It is stable from then until the next trigger.
- `commit` is registered: one cycle after the `can_commit` that is sampled in COMMIT_WAIT.
- `can_commit` arriving in the same cycle as the last POST write is not honored; the next `can_commit` commits.
- State transitions take effect on the clock edge of the qualifying event.

## Configuration
- `SCOPE_CAPTURE_AUTO_EN` defined:
  - Auto mode works as described.
  - The timeout counter of $\lceil\log_2(\text{AUTO\_TIMEOUT}+1)\rceil$ bits is present.
- Not defined:
  - Mode 1 behaves exactly as normal mode.
  - `auto_fired` is tied to 0.
  - The timeout counter is not built.

## Structure
- Shared package `scope_pkg`:
  - State enum.
  - Mode encodings `MODE_NORMAL`, `MODE_AUTO`, `MODE_SINGLE`.
- One sub-module, `sample_edge_det`:
  - Holds the `sample_tick`-qualified `trig_prev` register and the rising-edge output.
  - Has a synchronous clear for FILL entry.
- Counters (FILL/POST count, holdoff, timeout) live in the top module and share one down-counter where their states are exclusive.

## Test plan
All scenarios use AW=4 (depth 16), PRETRIG=4, HOLDOFF=2, AUTO_TIMEOUT=8 and `sample_tick` every cycle unless stated.
- **Normal trigger**: mode 0, `trig_in` rises at the write to addr 10 -> writes addr 0–3 in FILL, trigger at addr 10, `start_addr`=6; POST writes addr 11–15 and 0–5; `commit` asserts 1 cycle after `can_commit`; then 2 idle ticks, then FILL resumes at addr 6.
- **Trigger during FILL**: `trig_in` pulses at addr 1 and stays high -> no trigger; remains in ARMED until `trig_in` falls and rises again.
- **Auto timeout**: mode 1, `trig_in`=0 -> the 8th ARMED write (addr 11) is the trigger, `start_addr`=7, `commit` with `auto_fired`=1. Without `SCOPE_CAPTURE_AUTO_EN`: no commit, and state stays ARMED.
- **Single shot**: mode 2 -> no writes until `arm`; after `commit`, returns to IDLE with `busy`=0 and no further writes despite continued triggers.
- **Commit race**: `can_commit` coincident with the final POST write is ignored; a second `can_commit` 5 cycles later produces `commit` 1 cycle after it.
- **Reset mid-POST**: assert `reset_n`=0 during POST -> all outputs 0 immediately; after release, capture restarts from FILL at addr 0.
